age_ordered_rs: RTL and testbench
=================================

# age_ordered_rs

Parametrised, age-ordered reservation station: the successor of the out-of-order core's current RS. It accepts up to `N` renamed instructions per cycle from dispatch, wakes operands from `C` CDB ports (including same-cycle dispatch bypass), and issues to `P` issue ports, one FU class per port. Each port issues the oldest ready entry of its class. Branch squash and branch clear are applied via branch masks. It sits between rename/dispatch and the FU issue stage.

## Interface
Parameters:
- `DEPTH`, 16: number of entries (≥ N).
- `N`, 2: dispatch lanes.
- `C`, 2: CDB ports.
- `P`, 4: issue ports; port p serves FU class p.
- `TAG_W`, 6: physical tag width.
- `BM_W`, 4: branch-mask width.
- `PAY_W`, 64: opaque payload width (decoded fields, dest tag, etc.).

Derived widths: `CLS_W` = $clog2(P); `FS_W` = $clog2(N+1); `OC_W` = $clog2(DEPTH+1).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; state clears while `reset`=0.
- `dis_valid` in N: lane valid.
- `dis_class` in N×CLS_W: FU class / issue port.
- `dis_t1`, `dis_t2` in N×TAG_W: source tags.
- `dis_t1_rdy`, `dis_t2_rdy` in N: source ready from map table.
- `dis_bmask` in N×BM_W: branch mask.
- `dis_payload` in N×PAY_W: opaque payload.
- `free_slots` out FS_W: min(N, DEPTH − occupancy).
- `cdb_valid` in C; `cdb_tag` in C×TAG_W: broadcast tags.
- `br_id` in BM_W: one-hot branch bit.
- `br_squash` in 1; `br_clear` in 1: branch task.
- `iss_ready` in P: FU p can accept this cycle.
- `iss_valid` out P: port p presents an entry.
- `iss_payload` out P×PAY_W; `iss_bmask` out P×BM_W: issued entry contents.
- `occupancy` out OC_W: valid entry count.

## Operation
- Per entry state: valid, class, t1/t2 tag+ready, bmask, payload, plus relative age.
- **Dispatch:** lane i is accepted iff `dis_valid[i]` and i < `free_slots`. Upstream packs valid lanes low, and lanes at or above `free_slots` are ignored. Accepted lanes take the lowest-indexed free entries, where a free entry is one invalid at the start of the cycle. Lower lane is older than higher lane, and every new entry is younger than all resident entries.
- **Operand readiness at dispatch:** ready = `dis_tX_rdy` OR (some `cdb_valid[c]` with `cdb_tag[c]`==`dis_tX`). This is the bypass.
- **Wakeup:** a resident entry's tX ready sets when a valid CDB tag matches. Ready bits never clear except on dealloc.
- **Request:** entry requests port `class` when valid, t1 ready, t2 ready, and it is not being squashed this cycle (bmask & `br_id` ≠ 0 with `br_squash`).
- **Select:** per port, the oldest requester (age matrix, DEPTH×DEPTH bits). `iss_valid[p]` = any requester. The entry deallocates at the edge iff `iss_valid[p]` & `iss_ready[p]`. If not ready, the entry stays, and selection is re-evaluated next cycle.
- `iss_bmask` = stored mask with `br_id` bit cleared when `br_clear`.
- **Squash:** at the edge, all entries with bmask & `br_id` ≠ 0 are invalidated. Dispatch lanes with the same condition are accepted (they consume slots per `free_slots`) but not written.
- **Clear:** the `br_id` bit is cleared in resident and incoming masks.
- `br_squash` and `br_clear` together: squash wins, clear ignored.
- **Occupancy:** next = occ + written − issued − squashed, evaluated in OC_W+1 bits, never negative.

## Timing
- **Reset (asynchronous, `reset`=0):**
  - all entries invalid, age matrix zero;
  - `occupancy`=0, `free_slots`=min(N,DEPTH);
  - `iss_valid`=0;
  - `iss_payload` and `iss_bmask` are 0.

  Reset mid-operation discards everything, including in-flight dispatch lanes. Release is synchronous to `clock`.
- **Derivation of outputs:**
  - `free_slots` and `occupancy` come from registers only; there is no same-cycle credit from issue or squash.
  - Issue outputs are combinational from registered state plus `br_squash`, `br_clear`, and `br_id`.
- **Latencies:**
  - Dispatch at cycle t: issue at t+1 at earliest.
  - CDB at t for a resident entry: issue at t+1 at earliest. There is no same-cycle wake-and-issue.
  - A slot freed at t is reusable for dispatch at t+1.
- **Full:** `free_slots`=0 and all lanes are ignored.
- **Empty:** `iss_valid`=0.

## Configuration
- `RS_AGE_ORDER_EN` defined: oldest-first select via the age matrix, as above.
- `RS_AGE_ORDER_EN` undefined: age matrix not built; each port selects the lowest-index requester; all other behaviour identical.

## Test plan
- Reset, dispatch 2 ready ALU ops (class 0) at t0 → `occupancy`=2 at t1, `iss_valid[0]`=1 at t1 with lane-0 payload; `iss_ready[0]`=1 for two cycles → `occupancy` 0 at t3.
- Dispatch op with `dis_t1`=5, not ready, while `cdb_tag`=5 valid same cycle → issues at t+1. A resident entry waiting on tag 7, with CDB 7 at t → `iss_valid` at t+1, not at t.
- Fill DEPTH=16 → `free_slots`=0. Dispatch with `dis_valid`=11 is ignored. Issue one entry → `free_slots`=1 next cycle; only lane 0 is accepted.
- Entries A (bmask 0010) and B (0000) ready for port 1, `br_id`=0010 with `br_squash` → `iss_valid[1]` presents B; `occupancy` drops by 1 for squash (+1 if B issued). Same with `br_clear` → A's mask becomes 0000.
- Age order (macro on): dispatch Y into slot 3, then X into slot 0 after freeing it, both ready same port → Y issues first. Macro off → X first.
- Assert `reset`=0 mid-stream asynchronously → `iss_valid`=0 and `occupancy`=0 immediately, without a clock edge.

Source files
------------

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station with N-lane dispatch, C-port CDB wakeup and P issue ports, one FU class per port.
// Define RS_AGE_ORDER_EN for oldest-first select through an age matrix; the default build selects the lowest-index requester.
module age_ordered_rs #(
  parameter int DEPTH = 16,
  parameter int N     = 2,
  parameter int C     = 2,
  parameter int P     = 4,
  parameter int TAG_W = 6,
  parameter int BM_W  = 4,
  parameter int PAY_W = 64,
  localparam int CLS_W = (P > 1) ? $clog2(P) : 1,
  localparam int FS_W  = $clog2(N + 1),
  localparam int OC_W  = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       dis_valid,
  input  logic [N*CLS_W-1:0] dis_class,
  input  logic [N*TAG_W-1:0] dis_t1,
  input  logic [N*TAG_W-1:0] dis_t2,
  input  logic [N-1:0]       dis_t1_rdy,
  input  logic [N-1:0]       dis_t2_rdy,
  input  logic [N*BM_W-1:0]  dis_bmask,
  input  logic [N*PAY_W-1:0] dis_payload,
  output logic [FS_W-1:0]    free_slots,
  input  logic [C-1:0]       cdb_valid,
  input  logic [C*TAG_W-1:0] cdb_tag,
  input  logic [BM_W-1:0]    br_id,
  input  logic               br_squash,
  input  logic               br_clear,
  input  logic [P-1:0]       iss_ready,
  output logic [P-1:0]       iss_valid,
  output logic [P*PAY_W-1:0] iss_payload,
  output logic [P*BM_W-1:0]  iss_bmask,
  output logic [OC_W-1:0]    occupancy
);

  logic [DEPTH-1:0] valid_q, r1_q, r2_q;
  logic [CLS_W-1:0] cls_q [DEPTH];
  logic [TAG_W-1:0] t1_q  [DEPTH];
  logic [TAG_W-1:0] t2_q  [DEPTH];
  logic [BM_W-1:0]  bm_q  [DEPTH];
  logic [PAY_W-1:0] pay_q [DEPTH];
  logic [OC_W-1:0]  occ_q;
`ifdef RS_AGE_ORDER_EN
  // older_q[k][j] set means entry j is older than entry k
  logic [DEPTH-1:0] older_q [DEPTH];
`endif

  logic             do_clear;
  logic [BM_W-1:0]  clr_mask;
  logic [OC_W:0]    room;
  logic [N-1:0]     lane_wr;
  logic [DEPTH-1:0] alloc, kill, issued;
  int               lane_of [DEPTH];
  logic [DEPTH-1:0] req [P];
  logic [DEPTH-1:0] gnt [P];
  int               occ_next;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag, input logic [C-1:0] vld,
                                   input logic [C*TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int c = 0; c < C; c++)
      if (vld[c] && tags[c*TAG_W +: TAG_W] == tag) cdb_hit = 1'b1;
  endfunction

  assign do_clear  = br_clear && !br_squash;
  assign clr_mask  = do_clear ? br_id : '0;
  assign occupancy = occ_q;

  always_comb begin
    room       = (OC_W+1)'(DEPTH) - {1'b0, occ_q};
    free_slots = (room > (OC_W+1)'(N)) ? FS_W'(N) : FS_W'(room);
  end

  // Lane i takes the i-th entry that was free at the start of the cycle; squashed lanes burn their slot unwritten.
  always_comb begin
    int n_free;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    lane_wr = '0;
    alloc   = '0;
    n_free  = 0;
    for (int k = 0; k < DEPTH; k++) lane_of[k] = 0;
    for (int i = 0; i < N; i++)
      lane_wr[i] = dis_valid[i] && (i < int'(free_slots))
                   && !(br_squash && |(dis_bmask[i*BM_W +: BM_W] & br_id));
    for (int k = 0; k < DEPTH; k++) begin
      if (!valid_q[k]) begin
        for (int i = 0; i < N; i++)
          if (n_free == i && lane_wr[i]) begin
            alloc[k]   = 1'b1;
            lane_of[k] = i;
          end
        n_free++;
      end
    end
  end

  always_comb begin
    issued      = '0;
    iss_valid   = '0;
    iss_payload = '0;
    iss_bmask   = '0;
    for (int k = 0; k < DEPTH; k++)
      kill[k] = valid_q[k] && br_squash && |(bm_q[k] & br_id);
    for (int p = 0; p < P; p++) begin
      gnt[p] = '0;
      for (int k = 0; k < DEPTH; k++)
        req[p][k] = valid_q[k] && r1_q[k] && r2_q[k] && !kill[k] && (cls_q[k] == CLS_W'(p));
`ifdef RS_AGE_ORDER_EN
      for (int k = 0; k < DEPTH; k++)
        gnt[p][k] = req[p][k] && !(|(req[p] & older_q[k]));
`else
      for (int k = DEPTH - 1; k >= 0; k--)
        if (req[p][k]) begin
          gnt[p]    = '0;
          gnt[p][k] = 1'b1;
        end
`endif
      iss_valid[p] = |req[p];
      for (int k = 0; k < DEPTH; k++)
        if (gnt[p][k]) begin
          iss_payload[p*PAY_W +: PAY_W] = iss_payload[p*PAY_W +: PAY_W] | pay_q[k];
          iss_bmask[p*BM_W +: BM_W]     = iss_bmask[p*BM_W +: BM_W] | (bm_q[k] & ~clr_mask);
        end
      if (iss_valid[p] && iss_ready[p]) issued = issued | gnt[p];
    end
  end

  // Issued and squashed sets are disjoint because a squashed entry never requests.
  always_comb begin
    int n_wr, n_iss, n_kill;
    n_wr   = 0;
    n_iss  = 0;
    n_kill = 0;
    for (int i = 0; i < N; i++) n_wr += int'(lane_wr[i]);
    for (int k = 0; k < DEPTH; k++) begin
      n_iss  += int'(issued[k]);
      n_kill += int'(kill[k]);
    end
    occ_next = int'(occ_q) + n_wr - n_iss - n_kill;
  end

  // NOTE: sequential state uses <= so every entry updates from the same pre-edge snapshot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      occ_q   <= '0;
    end else begin
      occ_q <= OC_W'(occ_next);
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc[k]) begin
          valid_q[k] <= 1'b1;
          r1_q[k]    <= dis_t1_rdy[lane_of[k]]
                        || cdb_hit(dis_t1[lane_of[k]*TAG_W +: TAG_W], cdb_valid, cdb_tag);
          r2_q[k]    <= dis_t2_rdy[lane_of[k]]
                        || cdb_hit(dis_t2[lane_of[k]*TAG_W +: TAG_W], cdb_valid, cdb_tag);
        end else begin
          if (issued[k] || kill[k]) valid_q[k] <= 1'b0;
          if (cdb_hit(t1_q[k], cdb_valid, cdb_tag)) r1_q[k] <= 1'b1;
          if (cdb_hit(t2_q[k], cdb_valid, cdb_tag)) r2_q[k] <= 1'b1;
        end
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // A new entry is younger than everything not allocating now and than lower lanes allocating with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) older_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        for (int j = 0; j < DEPTH; j++)
          if (alloc[k])
            older_q[k][j] <= (j != k) && (!alloc[j] || lane_of[j] < lane_of[k]);
          else if (alloc[j])
            older_q[k][j] <= 1'b0;
    end
  end
`endif

  // NOTE: entry contents are not reset; valid_q qualifies every read of them.
  always_ff @(posedge clock) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc[k]) begin
        cls_q[k] <= dis_class[lane_of[k]*CLS_W +: CLS_W];
        t1_q[k]  <= dis_t1[lane_of[k]*TAG_W +: TAG_W];
        t2_q[k]  <= dis_t2[lane_of[k]*TAG_W +: TAG_W];
        bm_q[k]  <= dis_bmask[lane_of[k]*BM_W +: BM_W] & ~clr_mask;
        pay_q[k] <= dis_payload[lane_of[k]*PAY_W +: PAY_W];
      end else begin
        bm_q[k]  <= bm_q[k] & ~clr_mask;
      end
    end
  end

endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs: dispatch/issue, bypass and wakeup, full, squash/clear, select order, async reset.
module tb_age_ordered_rs;
  localparam int DEPTH = 16, N = 2, C = 2, P = 4, TAG_W = 6, BM_W = 4, PAY_W = 64;

  logic               clock, reset;
  logic [N-1:0]       dis_valid, dis_t1_rdy, dis_t2_rdy;
  logic [N*2-1:0]     dis_class;
  logic [N*TAG_W-1:0] dis_t1, dis_t2;
  logic [N*BM_W-1:0]  dis_bmask;
  logic [N*PAY_W-1:0] dis_payload;
  logic [1:0]         free_slots;
  logic [C-1:0]       cdb_valid;
  logic [C*TAG_W-1:0] cdb_tag;
  logic [BM_W-1:0]    br_id;
  logic               br_squash, br_clear;
  logic [P-1:0]       iss_ready, iss_valid;
  logic [P*PAY_W-1:0] iss_payload;
  logic [P*BM_W-1:0]  iss_bmask;
  logic [4:0]         occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  age_ordered_rs #(.DEPTH(DEPTH), .N(N), .C(C), .P(P), .TAG_W(TAG_W), .BM_W(BM_W), .PAY_W(PAY_W)) dut (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_class(dis_class), .dis_t1(dis_t1), .dis_t2(dis_t2),
    .dis_t1_rdy(dis_t1_rdy), .dis_t2_rdy(dis_t2_rdy), .dis_bmask(dis_bmask), .dis_payload(dis_payload),
    .free_slots(free_slots), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .br_id(br_id), .br_squash(br_squash), .br_clear(br_clear),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_payload(iss_payload), .iss_bmask(iss_bmask),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    dis_valid = '0; dis_class = '0; dis_t1 = '0; dis_t2 = '0;
    dis_t1_rdy = '0; dis_t2_rdy = '0; dis_bmask = '0; dis_payload = '0;
    cdb_valid = '0; cdb_tag = '0; br_id = '0; br_squash = 1'b0; br_clear = 1'b0;
    iss_ready = '0;
  endtask

  task automatic lane(input int i, input int cls, input int t1, input bit r1, input int t2,
                      input bit r2, input logic [3:0] bm, input logic [63:0] pay);
    dis_valid[i]                  = 1'b1;
    dis_class[i*2 +: 2]           = 2'(cls);
    dis_t1[i*TAG_W +: TAG_W]      = TAG_W'(t1);
    dis_t2[i*TAG_W +: TAG_W]      = TAG_W'(t2);
    dis_t1_rdy[i]                 = r1;
    dis_t2_rdy[i]                 = r2;
    dis_bmask[i*BM_W +: BM_W]     = bm;
    dis_payload[i*PAY_W +: PAY_W] = pay;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [63:0] pay_of(input int p);
    return iss_payload[p*PAY_W +: PAY_W];
  endfunction

  function automatic logic [63:0] bm_of(input int p);
    return 64'(iss_bmask[p*BM_W +: BM_W]);
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    #3;
    check("rst_occ", 64'(occupancy), 0);
    check("rst_free", 64'(free_slots), 2);
    check("rst_iss_valid", 64'(iss_valid), 0);
    check("rst_payload", pay_of(0), 0);
    check("rst_bmask", bm_of(0), 0);
    #10 reset = 1'b1;
    step();

    // Two ready ALU ops, drained over two cycles
    idle();
    lane(0, 0, 1, 1, 2, 1, 4'b0000, 64'hA1);
    lane(1, 0, 3, 1, 4, 1, 4'b0000, 64'hA2);
    settle();
    check("t0_no_issue", 64'(iss_valid), 0);
    step();
    idle(); iss_ready[0] = 1'b1; settle();
    check("t1_occ", 64'(occupancy), 2);
    check("t1_valid0", 64'(iss_valid[0]), 1);
    check("t1_pay_a1", pay_of(0), 64'hA1);
    check("t1_free", 64'(free_slots), 2);
    step();
    idle(); iss_ready[0] = 1'b1; settle();
    check("t2_occ", 64'(occupancy), 1);
    check("t2_pay_a2", pay_of(0), 64'hA2);
    step();
    idle(); settle();
    check("t3_occ", 64'(occupancy), 0);
    check("t3_empty", 64'(iss_valid), 0);

    // Dispatch bypass on tag 5, then resident wakeup on tag 7
    lane(0, 2, 5, 0, 6, 1, 4'b0000, 64'hB1);
    cdb_valid = 2'b01; cdb_tag[5:0] = 6'd5;
    settle();
    step();
    idle(); settle();
    check("byp_valid", 64'(iss_valid[2]), 1);
    check("byp_pay", pay_of(2), 64'hB1);
    iss_ready[2] = 1'b1;
    step();
    idle(); lane(0, 3, 8, 1, 7, 0, 4'b0000, 64'hC1);
    step();
    idle(); settle();
    check("wait_t7", 64'(iss_valid[3]), 0);
    cdb_valid = 2'b10; cdb_tag[11:6] = 6'd7; settle();
    check("wake_same_cycle", 64'(iss_valid[3]), 0);
    step();
    idle(); settle();
    check("wake_next_valid", 64'(iss_valid[3]), 1);
    check("wake_next_pay", pay_of(3), 64'hC1);
    iss_ready[3] = 1'b1;
    step();
    idle(); settle();
    check("wake_drained", 64'(occupancy), 0);

    // Fill all 16 entries with ready class-1 ops held by iss_ready=0
    for (int c = 0; c < 8; c++) begin
      idle();
      lane(0, 1, 0, 1, 0, 1, 4'b0000, 64'(100 + 2*c));
      lane(1, 1, 0, 1, 0, 1, 4'b0000, 64'(101 + 2*c));
      step();
    end
    idle(); settle();
    check("full_occ", 64'(occupancy), 16);
    check("full_free", 64'(free_slots), 0);
    check("full_oldest", pay_of(1), 64'd100);
    lane(0, 2, 0, 1, 0, 1, 4'b0000, 64'h300);
    lane(1, 2, 0, 1, 0, 1, 4'b0000, 64'h301);
    step();
    idle(); settle();
    check("full_ignored_occ", 64'(occupancy), 16);
    check("full_ignored_port2", 64'(iss_valid[2]), 0);
    iss_ready[1] = 1'b1;
    step();
    idle(); settle();
    check("one_freed_free", 64'(free_slots), 1);
    check("one_freed_occ", 64'(occupancy), 15);
    lane(0, 2, 0, 1, 0, 1, 4'b0000, 64'h200);
    lane(1, 2, 0, 1, 0, 1, 4'b0000, 64'h201);
    step();
    idle(); settle();
    check("lane0_only_occ", 64'(occupancy), 16);
    check("lane0_only_free", 64'(free_slots), 0);
    check("lane0_only_pay", pay_of(2), 64'h200);
    iss_ready[2] = 1'b1;
    step();
    idle(); settle();
    check("lane1_dropped", 64'(iss_valid[2]), 0);
    check("lane1_dropped_occ", 64'(occupancy), 15);

    // Asynchronous reset with no clock edge
    check("pre_reset_valid", 64'(iss_valid[1]), 1);
    reset = 1'b0;
    #1;
    check("async_iss_valid", 64'(iss_valid), 0);
    check("async_occ", 64'(occupancy), 0);
    check("async_free", 64'(free_slots), 2);
    #1 reset = 1'b1;
    step();

    // Squash: A(0010) killed, B(0000) issues on port 1
    idle();
    lane(0, 1, 0, 1, 0, 1, 4'b0010, 64'hAA);
    lane(1, 1, 0, 1, 0, 1, 4'b0000, 64'hBB);
    step();
    idle(); settle();
    check("sq_before", pay_of(1), 64'hAA);
    br_id = 4'b0010; br_squash = 1'b1; iss_ready[1] = 1'b1; settle();
    check("sq_valid", 64'(iss_valid[1]), 1);
    check("sq_pay_b", pay_of(1), 64'hBB);
    check("sq_bm_b", bm_of(1), 0);
    step();
    idle(); settle();
    check("sq_occ", 64'(occupancy), 0);
    check("sq_empty", 64'(iss_valid), 0);
    lane(0, 1, 0, 1, 0, 1, 4'b0010, 64'hCC);
    lane(1, 1, 0, 1, 0, 1, 4'b0001, 64'hDD);
    br_id = 4'b0010; br_squash = 1'b1;
    step();
    idle(); settle();
    check("sq_lane_occ", 64'(occupancy), 1);
    check("sq_lane_pay", pay_of(1), 64'hDD);
    iss_ready[1] = 1'b1;
    step();

    // Clear: bit 0010 removed from issued and resident masks
    idle();
    lane(0, 1, 0, 1, 0, 1, 4'b0010, 64'hE1);
    lane(1, 1, 0, 1, 0, 1, 4'b0110, 64'hE2);
    step();
    idle(); br_id = 4'b0010; br_clear = 1'b1; settle();
    check("clr_pay", pay_of(1), 64'hE1);
    check("clr_bm_out", bm_of(1), 0);
    step();
    idle(); settle();
    check("clr_bm_stored", bm_of(1), 0);
    br_id = 4'b0010; br_squash = 1'b1; iss_ready[1] = 1'b1; settle();
    check("clr_not_squashed", pay_of(1), 64'hE1);
    step();
    idle(); settle();
    check("clr_b_pay", pay_of(1), 64'hE2);
    check("clr_b_bm", bm_of(1), 64'h4);
    iss_ready[1] = 1'b1;
    step();
    idle(); settle();
    check("clr_drained", 64'(occupancy), 0);

    // Select order: Y in slot 3 is older than X placed later in slot 0
    lane(0, 0, 0, 1, 0, 1, 4'b0000, 64'h10);
    lane(1, 3, 20, 0, 0, 1, 4'b0000, 64'h11);
    step();
    idle();
    lane(0, 3, 20, 0, 0, 1, 4'b0000, 64'h12);
    lane(1, 1, 0, 1, 0, 1, 4'b0000, 64'h33);
    step();
    idle(); iss_ready[0] = 1'b1; settle();
    check("age_slot0", pay_of(0), 64'h10);
    check("age_y_alone", pay_of(1), 64'h33);
    step();
    idle(); lane(0, 1, 0, 1, 0, 1, 4'b0000, 64'h44);
    step();
    idle(); settle();
    check("age_occ", 64'(occupancy), 4);
`ifdef RS_AGE_ORDER_EN
    check("age_first", pay_of(1), 64'h33);
`else
    check("age_first", pay_of(1), 64'h44);
`endif
    iss_ready[1] = 1'b1;
    step();
    idle(); settle();
`ifdef RS_AGE_ORDER_EN
    check("age_second", pay_of(1), 64'h44);
`else
    check("age_second", pay_of(1), 64'h33);
`endif
    iss_ready[1] = 1'b1;
    step();
    idle(); settle();
    check("age_port1_empty", 64'(iss_valid[1]), 0);
    check("age_final_occ", 64'(occupancy), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
